// File: rtl/edge_bbox_overlay.sv
// Tracks the per-frame bounding box and count of Sobel edge pixels, latches them at each
// vsync rising edge, and re-emits the stream as RGB565 with the latched box drawn in red.
module edge_bbox_overlay #(
  parameter int unsigned IMG_W   = 640,
  parameter int unsigned IMG_H   = 480,
  parameter int unsigned MARGIN  = 2,
  parameter int unsigned MIN_PIX = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        sobel_de,
  input  logic        sobel_hsync,
  input  logic        sobel_vsync,
  input  logic        sobel_data,
  output logic [10:0] box_xmin,
  output logic [10:0] box_xmax,
  output logic [10:0] box_ymin,
  output logic [10:0] box_ymax,
  output logic        box_valid,
  output logic [15:0] edge_cnt,
  output logic        frame_done,
  output logic        ovl_de,
  output logic        ovl_hsync,
  output logic        ovl_vsync,
  output logic [15:0] ovl_data
);

  localparam logic [10:0] XLo    = 11'(MARGIN);
  localparam logic [10:0] XHi    = 11'(IMG_W - 1 - MARGIN);
  localparam logic [10:0] YLo    = 11'(MARGIN);
  localparam logic [10:0] YHi    = 11'(IMG_H - 1 - MARGIN);
  localparam logic [15:0] MinPix = 16'(MIN_PIX);
  localparam logic [10:0] PosMax = 11'h7FF;

  logic        de_q, vsync_q, armed_q;
  logic [10:0] x_q, y_q;
  logic [10:0] acc_xmin_q, acc_xmax_q, acc_ymin_q, acc_ymax_q;
  logic [15:0] cnt_q;

  logic        vsync_rise, de_fall, count_pix, x_on, y_on;
  logic [15:0] ovl_data_d;

  always_comb begin
    vsync_rise = sobel_vsync & ~vsync_q;
    de_fall    = de_q & ~sobel_de;
    // The frame boundary wins over a coincident pixel, so that pixel is never counted.
    count_pix  = sobel_de & ~sobel_data & ~vsync_rise &
                 (x_q >= XLo) & (x_q <= XHi) & (y_q >= YLo) & (y_q <= YHi);
    x_on = ((x_q == box_xmin) || (x_q == box_xmax)) && (y_q >= box_ymin) && (y_q <= box_ymax);
    y_on = ((y_q == box_ymin) || (y_q == box_ymax)) && (x_q >= box_xmin) && (x_q <= box_xmax);
    ovl_data_d = 16'h0000;
    if (sobel_de) begin
      if (box_valid && (x_on || y_on)) ovl_data_d = 16'hF800;
      else if (sobel_data)             ovl_data_d = 16'hFFFF;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      de_q       <= 1'b0;
      vsync_q    <= 1'b0;
      armed_q    <= 1'b0;
      x_q        <= '0;
      y_q        <= '0;
      acc_xmin_q <= PosMax;
      acc_xmax_q <= '0;
      acc_ymin_q <= PosMax;
      acc_ymax_q <= '0;
      cnt_q      <= '0;
      box_xmin   <= '0;
      box_xmax   <= '0;
      box_ymin   <= '0;
      box_ymax   <= '0;
      box_valid  <= 1'b0;
      edge_cnt   <= '0;
      frame_done <= 1'b0;
      ovl_de     <= 1'b0;
      ovl_hsync  <= 1'b0;
      ovl_vsync  <= 1'b0;
      ovl_data   <= '0;
    end else begin
      de_q       <= sobel_de;
      vsync_q    <= sobel_vsync;
      ovl_de     <= sobel_de;
      ovl_hsync  <= sobel_hsync;
      ovl_vsync  <= sobel_vsync;
      ovl_data   <= ovl_data_d;
      frame_done <= 1'b0;

      if (vsync_rise) begin
        x_q <= '0;
        y_q <= '0;
      end else if (sobel_de) begin
        if (x_q != PosMax) x_q <= x_q + 11'd1;
      end else if (de_fall) begin
        x_q <= '0;
        if (y_q != PosMax) y_q <= y_q + 11'd1;
      end

      if (vsync_rise) begin
        // The first boundary after reset only arms; the partial frame before it is dropped.
        armed_q <= 1'b1;
        if (armed_q) begin
          edge_cnt   <= cnt_q;
          frame_done <= 1'b1;
          if (cnt_q >= MinPix) begin
            box_xmin  <= acc_xmin_q;
            box_xmax  <= acc_xmax_q;
            box_ymin  <= acc_ymin_q;
            box_ymax  <= acc_ymax_q;
            box_valid <= 1'b1;
          end else begin
            box_valid <= 1'b0;
          end
        end
        acc_xmin_q <= PosMax;
        acc_xmax_q <= '0;
        acc_ymin_q <= PosMax;
        acc_ymax_q <= '0;
        cnt_q      <= '0;
      end else if (count_pix) begin
        if (x_q < acc_xmin_q) acc_xmin_q <= x_q;
        if (x_q > acc_xmax_q) acc_xmax_q <= x_q;
        if (y_q < acc_ymin_q) acc_ymin_q <= y_q;
        if (y_q > acc_ymax_q) acc_ymax_q <= y_q;
        if (cnt_q != 16'hFFFF) cnt_q <= cnt_q + 16'd1;
      end
    end
  end

endmodule

// File: tb/tb_edge_bbox_overlay.sv
// Directed bench for edge_bbox_overlay: a 16x8 instance for box/count/overlay behaviour and
// a larger instance for count saturation.
module tb_edge_bbox_overlay;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Small instance: IMG_W=16, IMG_H=8, MARGIN=1, MIN_PIX=4
  logic        s_de = 1'b0, s_hsync = 1'b0, s_vsync = 1'b0, s_data = 1'b1;
  logic [10:0] xmin, xmax, ymin, ymax;
  logic        valid, frame_done, o_de, o_hsync, o_vsync;
  logic [15:0] cnt, o_data;

  edge_bbox_overlay #(.IMG_W(16), .IMG_H(8), .MARGIN(1), .MIN_PIX(4)) dut (
    .clk(clk), .rst(rst),
    .sobel_de(s_de), .sobel_hsync(s_hsync), .sobel_vsync(s_vsync), .sobel_data(s_data),
    .box_xmin(xmin), .box_xmax(xmax), .box_ymin(ymin), .box_ymax(ymax),
    .box_valid(valid), .edge_cnt(cnt), .frame_done(frame_done),
    .ovl_de(o_de), .ovl_hsync(o_hsync), .ovl_vsync(o_vsync), .ovl_data(o_data)
  );

  // Large instance: 282x252 with MARGIN=1 gives a 280x250 = 70000 pixel window
  logic        b_de = 1'b0, b_hsync = 1'b0, b_vsync = 1'b0, b_data = 1'b1;
  logic [10:0] b_xmin, b_xmax, b_ymin, b_ymax;
  logic        b_valid, b_done, b_ode, b_ohs, b_ovs;
  logic [15:0] b_cnt, b_odata;

  edge_bbox_overlay #(.IMG_W(282), .IMG_H(252), .MARGIN(1), .MIN_PIX(64)) dut_big (
    .clk(clk), .rst(rst),
    .sobel_de(b_de), .sobel_hsync(b_hsync), .sobel_vsync(b_vsync), .sobel_data(b_data),
    .box_xmin(b_xmin), .box_xmax(b_xmax), .box_ymin(b_ymin), .box_ymax(b_ymax),
    .box_valid(b_valid), .edge_cnt(b_cnt), .frame_done(b_done),
    .ovl_de(b_ode), .ovl_hsync(b_ohs), .ovl_vsync(b_ovs), .ovl_data(b_odata)
  );

  logic edge_map [0:7][0:15];

  task automatic clear_map();
    for (int yy = 0; yy < 8; yy++)
      for (int xx = 0; xx < 16; xx++) edge_map[yy][xx] = 1'b0;
  endtask

  task automatic map_four(input bit with_fourth);
    clear_map();
    edge_map[2][3]  = 1'b1;
    edge_map[2][10] = 1'b1;
    edge_map[5][3]  = 1'b1;
    if (with_fourth) edge_map[5][10] = 1'b1;
  endtask

  task automatic vsync_pulse(output int pulses);
    pulses = 0;
    s_vsync = 1'b1; s_de = 1'b0; s_data = 1'b1; s_hsync = 1'b0;
    repeat (3) begin
      @(posedge clk); #1;
      pulses += int'(frame_done);
      checks++;
      if (o_vsync !== 1'b1) begin
        errors++;
        $display("FAIL ovl_vsync_pulse: got %b want 1", o_vsync);
      end
    end
    s_vsync = 1'b0;
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input bit chk);
    logic [15:0] exp;
    for (int yy = 0; yy < 8; yy++) begin
      for (int xx = 0; xx < 16; xx++) begin
        s_de = 1'b1; s_hsync = 1'b0; s_data = ~edge_map[yy][xx];
        @(posedge clk); #1;
        if (chk) begin
          if ((((xx == 3) || (xx == 10)) && (yy >= 2) && (yy <= 5)) ||
              (((yy == 2) || (yy == 5)) && (xx >= 3) && (xx <= 10)))
            exp = 16'hF800;
          else
            exp = s_data ? 16'hFFFF : 16'h0000;
          checks++;
          if (o_data !== exp || o_de !== 1'b1) begin
            errors++;
            $display("FAIL ovl_pixel (%0d,%0d): got data=%h de=%b want data=%h de=1",
                     xx, yy, o_data, o_de, exp);
          end
        end
      end
      for (int i = 0; i < 4; i++) begin
        s_de = 1'b0; s_data = 1'b1; s_hsync = (i == 1 || i == 2);
        @(posedge clk); #1;
        if (chk) begin
          checks++;
          if (o_data !== 16'h0000 || o_de !== 1'b0 || o_hsync !== s_hsync) begin
            errors++;
            $display("FAIL ovl_blank y=%0d i=%0d: got data=%h de=%b hs=%b want 0000 0 %b",
                     yy, i, o_data, o_de, o_hsync, s_hsync);
          end
        end
      end
    end
    s_hsync = 1'b0;
  endtask

  task automatic check_box(input string name, input logic [10:0] ex0, ex1, ey0, ey1,
                           input logic ev, input logic [15:0] ec);
    checks++;
    if (xmin !== ex0 || xmax !== ex1 || ymin !== ey0 || ymax !== ey1 || valid !== ev ||
        cnt !== ec) begin
      errors++;
      $display("FAIL %s: got box=(%0d,%0d,%0d,%0d) valid=%b cnt=%0d want (%0d,%0d,%0d,%0d) %b %0d",
               name, xmin, xmax, ymin, ymax, valid, cnt, ex0, ex1, ey0, ey1, ev, ec);
    end
  endtask

  task automatic check_pulses(input string name, input int got, input int want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %0d frame_done pulses want %0d", name, got, want);
    end
  endtask

  task automatic check_all_zero(input string name);
    checks++;
    if (xmin !== 0 || xmax !== 0 || ymin !== 0 || ymax !== 0 || valid !== 0 || cnt !== 0 ||
        frame_done !== 0 || o_de !== 0 || o_hsync !== 0 || o_vsync !== 0 || o_data !== 0) begin
      errors++;
      $display("FAIL %s: got box=(%0d,%0d,%0d,%0d) v=%b cnt=%0d fd=%b ovl=%b%b%b %h want all 0",
               name, xmin, xmax, ymin, ymax, valid, cnt, frame_done, o_de, o_hsync, o_vsync,
               o_data);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check_all_zero("reset_state");
    rst = 1'b0;
  endtask

  task automatic test_first_frames();
    int p;
    vsync_pulse(p);
    check_pulses("first_vsync_no_done", p, 0);
    check_box("first_vsync_hold", 0, 0, 0, 0, 1'b0, 16'd0);
    map_four(1'b1);
    send_frame(1'b0);
    vsync_pulse(p);
    check_pulses("frame2_done", p, 1);
    check_box("frame2_box", 11'd3, 11'd10, 11'd2, 11'd5, 1'b1, 16'd4);
  endtask

  task automatic test_low_count();
    int p;
    map_four(1'b0);
    send_frame(1'b0);
    vsync_pulse(p);
    check_pulses("low_count_done", p, 1);
    check_box("low_count_box", 11'd3, 11'd10, 11'd2, 11'd5, 1'b0, 16'd3);
  endtask

  task automatic test_margin();
    int p;
    clear_map();
    for (int xx = 0; xx < 16; xx++) edge_map[0][xx] = 1'b1;
    for (int yy = 0; yy < 8; yy++) begin
      edge_map[yy][0]  = 1'b1;
      edge_map[yy][15] = 1'b1;
    end
    send_frame(1'b0);
    vsync_pulse(p);
    check_pulses("margin_done", p, 1);
    check_box("margin_excluded", 11'd3, 11'd10, 11'd2, 11'd5, 1'b0, 16'd0);
  endtask

  task automatic test_overlay();
    int p;
    map_four(1'b1);
    send_frame(1'b0);
    vsync_pulse(p);
    check_box("overlay_setup_box", 11'd3, 11'd10, 11'd2, 11'd5, 1'b1, 16'd4);
    clear_map();
    send_frame(1'b1);
    vsync_pulse(p);
    check_pulses("overlay_frame_done", p, 1);
    check_box("overlay_blank_frame", 11'd3, 11'd10, 11'd2, 11'd5, 1'b0, 16'd0);
  endtask

  task automatic test_reset_mid_frame();
    int p;
    map_four(1'b1);
    send_frame(1'b0);
    vsync_pulse(p);
    check_box("midrst_setup", 11'd3, 11'd10, 11'd2, 11'd5, 1'b1, 16'd4);
    for (int yy = 0; yy < 4; yy++)
      for (int xx = 0; xx < 16; xx++) begin
        s_de = 1'b1; s_data = ~edge_map[yy][xx];
        @(posedge clk); #1;
      end
    s_de = 1'b1; s_hsync = 1'b1; s_data = 1'b1;
    rst = 1'b1;
    @(posedge clk); #1;
    check_all_zero("midrst_outputs");
    rst = 1'b0; s_de = 1'b0; s_hsync = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    vsync_pulse(p);
    check_pulses("midrst_first_vsync", p, 0);
    send_frame(1'b0);
    vsync_pulse(p);
    check_pulses("midrst_next_done", p, 1);
    check_box("midrst_next_box", 11'd3, 11'd10, 11'd2, 11'd5, 1'b1, 16'd4);
  endtask

  task automatic big_vsync(output int pulses);
    pulses = 0;
    b_vsync = 1'b1; b_de = 1'b0;
    repeat (3) begin
      @(posedge clk); #1;
      pulses += int'(b_done);
    end
    b_vsync = 1'b0;
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic test_saturate();
    int p;
    big_vsync(p);
    check_pulses("sat_first_vsync", p, 0);
    for (int yy = 0; yy < 252; yy++) begin
      b_de = 1'b1; b_data = 1'b0;
      repeat (282) @(posedge clk);
      #1;
      b_de = 1'b0; b_data = 1'b1;
      repeat (2) @(posedge clk);
      #1;
    end
    big_vsync(p);
    check_pulses("sat_done", p, 1);
    checks++;
    if (b_cnt !== 16'hFFFF || b_valid !== 1'b1 || b_xmin !== 11'd1 || b_xmax !== 11'd280 ||
        b_ymin !== 11'd1 || b_ymax !== 11'd250) begin
      errors++;
      $display("FAIL saturate: got cnt=%h valid=%b box=(%0d,%0d,%0d,%0d) want ffff 1 (1,280,1,250)",
               b_cnt, b_valid, b_xmin, b_xmax, b_ymin, b_ymax);
    end
  endtask

  initial begin
    test_reset();
    test_first_frames();
    test_low_count();
    test_margin();
    test_overlay();
    test_reset_mid_frame();
    test_saturate();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/edge_bbox_overlay.md
Name: edge_bbox_overlay

Overview:
- Downstream consumer of the Sobel edge stage.
- Takes the 1-bit edge stream with its delayed de/hsync/vsync and tracks the bounding box of edge pixels per frame, plus the edge-pixel count.
- Latches the box at each frame boundary.
- Re-emits the stream as RGB565 for the display path: edges black, background white, previous frame's box drawn in red.

Parameters:
- IMG_W, 640, active pixels per line; pixels with x >= IMG_W are ignored for statistics.
- IMG_H, 480, active lines per frame; lines with y >= IMG_H are ignored for statistics.
- MARGIN, 2, border width in pixels excluded from statistics (suppresses Sobel border artefacts).
- MIN_PIX, 64, minimum edge-pixel count for a frame's box to be valid.

Ports:
- clk, input, 1, pixel clock.
- rst, input, 1, synchronous active-high reset.
- sobel_de, input, 1, pixel valid.
- sobel_hsync, input, 1, line sync (passed through only).
- sobel_vsync, input, 1, frame sync; rising edge = frame boundary.
- sobel_data, input, 1, 0 = edge pixel, 1 = background.
- box_xmin / box_xmax, output, 11, latched box columns.
- box_ymin / box_ymax, output, 11, latched box rows.
- box_valid, output, 1, latched box meets MIN_PIX.
- edge_cnt, output, 16, latched edge-pixel count of last frame (saturating).
- frame_done, output, 1, one-cycle pulse when box/count are latched.
- ovl_de / ovl_hsync / ovl_vsync, output, 1 each, syncs delayed by 1 clk.
- ovl_data, output, 16, RGB565 pixel.

Behaviour:
- Reset values: all box_* = 0, box_valid = 0, edge_cnt = 0, frame_done = 0, ovl_* = 0.
- Reset internals: counters and accumulators cleared, armed = 0.
- Reset mid-frame discards the partial frame.

Position counters:
- x: increments on each cycle with sobel_de = 1 and saturates at 2047.
- x clears on the de falling edge (registered de = 1, current de = 0). y increments on the same edge and saturates at 2047.
- x and y clear on the vsync rising edge.

Statistics window:
- A pixel counts only when all hold: sobel_de = 1, sobel_data = 0, MARGIN <= x <= IMG_W-1-MARGIN, MARGIN <= y <= IMG_H-1-MARGIN.
- Accumulator init values: xmin = ymin = 11'h7FF, xmax = ymax = 0, cnt = 0.
- A counted pixel updates min/max with x/y; cnt increments, saturating at 16'hFFFF.

Frame boundary (vsync rising edge):
- If armed = 0: set armed = 1, clear accumulators, no frame_done, outputs held. This is the first boundary after reset; the partial frame is dropped.
- If armed = 1, on the same cycle:
  - edge_cnt <= cnt.
  - frame_done = 1 for exactly one clk.
  - If cnt >= MIN_PIX: box_* <= accumulators and box_valid <= 1.
  - Otherwise: box_valid <= 0 and box_* hold.
  - Accumulators reinitialise. The latch uses pre-clear values.
- A vsync edge coinciding with sobel_de = 1: the boundary takes priority and that pixel is not counted.

Overlay (registered, latency 1 clk; ovl_de/hsync/vsync are the inputs delayed 1 clk):
- Pixel on the box border gives 16'hF800. Border means box_valid = 1 and either:
  - x = box_xmin or x = box_xmax, with box_ymin <= y <= box_ymax; or
  - y = box_ymin or y = box_ymax, with box_xmin <= x <= box_xmax.
- Otherwise sobel_data = 0 gives 16'h0000 and sobel_data = 1 gives 16'hFFFF.
- sobel_de = 0 gives ovl_data = 16'h0000.
- The overlay always uses the currently latched box (previous frame), never the accumulating one.
- box_* change only at frame_done, so the box is stable across a whole output frame.

Test Plan:
1. Reset, two frames (IMG_W=16, IMG_H=8, MARGIN=1, MIN_PIX=4), edges at (3,2) (10,2) (3,5) (10,5) in frame 2.
   - First vsync edge: no frame_done.
   - After frame 2: frame_done 1 clk; box = (3,10,2,5); box_valid = 1; edge_cnt = 4.
2. Same frame with only 3 edges.
   - edge_cnt = 3; box_valid = 0; box_* unchanged from the prior valid box.
3. Edges only in row 0, column 0 and x = 15.
   - edge_cnt = 0; box_valid = 0 (margin exclusion).
4. Frame 3 all background, with box (3,10,2,5) latched.
   - ovl_data = F800 at (3..10, 2), (3..10, 5), (3, 2..5), (10, 2..5).
   - FFFF elsewhere during de; 0000 when de = 0.
   - ovl syncs are exactly 1 clk behind the inputs.
5. Assert rst mid-frame 2.
   - All outputs 0 next clk.
   - Next vsync edge gives no frame_done; the following frame reports normally.
6. Frame with 70000 edge pixels (large IMG_W/IMG_H).
   - edge_cnt = 16'hFFFF; box_valid = 1.
